// File: rtl/rf_write_sched_if.sv
// Signal bundle between the register-file write scheduler and its environment
// (pipeline writeback, load return, load issue, hazard lookups, register-file write port).
interface rf_write_sched_if;
  logic        a_valid;
  logic [3:0]  a_reg;
  logic [15:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [3:0]  b_reg;
  logic [15:0] b_data;
  logic        iss_valid;
  logic [3:0]  iss_reg;
  logic [3:0]  rd1_addr;
  logic [3:0]  rd2_addr;
  logic [3:0]  wd_addr;
  logic        rd1_busy;
  logic        rd2_busy;
  logic        wd_busy;
  logic        stall_wb;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] pend;
  logic        err;

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data, iss_valid, iss_reg,
           rd1_addr, rd2_addr, wd_addr,
    output b_ready, rd1_busy, rd2_busy, wd_busy, stall_wb, wr_en, wr_addr, wr_data, pend, err
  );

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data, iss_valid, iss_reg,
           rd1_addr, rd2_addr, wd_addr,
    input  b_ready, rd1_busy, rd2_busy, wd_busy, stall_wb, wr_en, wr_addr, wr_data, pend, err
  );
endinterface

// File: rtl/rf_write_sched.sv
// Shares the register-file write port between pipeline writeback (A) and load returns (B),
// keeps the pending-load scoreboard and forces a writeback bubble when B starves.
module rf_write_sched #(
  parameter int unsigned MAX_WAIT = 4,
  parameter bit          R0_ZERO  = 1'b1
) (
  input logic             clk,
  input logic             rst,
  rf_write_sched_if.slave bus
);

  localparam logic [3:0] CntLast = 4'(MAX_WAIT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StForce} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        stall_q, stall_d;
  logic        wr_en_q, wr_en_d;
  logic [3:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        wr_b_q, wr_b_d;
  logic [15:0] pend_q, pend_d;
  logic        err_q, err_d;

  logic        grant_b, refused, clr_hit, force_viol;
  logic [3:0]  win_reg;
  logic [15:0] win_data;

  function automatic logic is_r0(input logic [3:0] r);
    return R0_ZERO && (r == 4'd0);
  endfunction

  assign grant_b    = bus.b_valid & ~bus.a_valid;
  assign refused    = bus.b_valid & bus.a_valid;
  assign win_reg    = bus.a_valid ? bus.a_reg : bus.b_reg;
  assign win_data   = bus.a_valid ? bus.a_data : bus.b_data;
  // A load return retires its pend bit at the edge that ends its write cycle.
  assign clr_hit    = wr_en_q & wr_b_q;
  assign force_viol = (state_q == StForce) & bus.a_valid;

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_b_d    = 1'b0;
    if (bus.a_valid | grant_b) begin
      wr_en_d   = ~is_r0(win_reg);
      wr_addr_d = win_reg;
      wr_data_d = win_data;
      wr_b_d    = grant_b;
    end
  end

  always_comb begin
    pend_d = pend_q;
    err_d  = err_q | force_viol;
    if (clr_hit) begin
      pend_d[wr_addr_q] = 1'b0;
      if (!pend_q[wr_addr_q]) err_d = 1'b1;
    end
    // Issue is applied after the clear so a same-edge set wins.
    if (bus.iss_valid) begin
      if (pend_q[bus.iss_reg] && !(clr_hit && (wr_addr_q == bus.iss_reg))) err_d = 1'b1;
      if (!is_r0(bus.iss_reg)) pend_d[bus.iss_reg] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_d = 1'b0;
    unique case (state_q)
      StIdle, StWait: begin
        if (refused) begin
          if (cnt_q == CntLast) begin
            state_d = StForce;
            cnt_d   = 4'd0;
            stall_d = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = cnt_q + 4'd1;
          end
        end else begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end
      end
      StForce: begin
        if (refused) begin
          state_d = StWait;
          cnt_d   = CntLast;
        end else begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      stall_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 4'd0;
      wr_data_q <= 16'd0;
      wr_b_q    <= 1'b0;
      pend_q    <= 16'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stall_q   <= stall_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_b_q    <= wr_b_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
    end
  end

  assign bus.b_ready  = grant_b;
  assign bus.rd1_busy = pend_q[bus.rd1_addr] & ~is_r0(bus.rd1_addr);
  assign bus.rd2_busy = pend_q[bus.rd2_addr] & ~is_r0(bus.rd2_addr);
  assign bus.wd_busy  = pend_q[bus.wd_addr] & ~is_r0(bus.wd_addr);
  assign bus.stall_wb = stall_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.pend     = pend_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_rf_write_sched.sv
// Bench for rf_write_sched: directed scenarios with literal expectations plus randomized
// traffic checked every cycle against a behavioural model of the write port and scoreboard.
module tb_rf_write_sched;

  localparam int unsigned MAX_WAIT = 4;
  localparam bit          R0_ZERO  = 1'b1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_write_sched_if bus ();

  rf_write_sched #(
    .MAX_WAIT (MAX_WAIT),
    .R0_ZERO  (R0_ZERO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: what the registered outputs hold during the current cycle.
  bit          m_wr_en, m_wr_b, m_err, m_stall, chk_en;
  bit [3:0]    m_wr_addr;
  bit [15:0]   m_wr_data, m_pend;
  int          m_streak;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit busy_of(input bit [15:0] p, input bit [3:0] a);
    return p[a] && !(R0_ZERO && a == 4'd0);
  endfunction

  // Compare then advance the model, once per cycle at the falling edge.
  initial begin
    bit        clr, ne;
    bit [15:0] np;
    bit [3:0]  wa;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("wr_en", 32'(bus.wr_en), 32'(m_wr_en));
        if (m_wr_en) begin
          check("wr_addr", 32'(bus.wr_addr), 32'(m_wr_addr));
          check("wr_data", 32'(bus.wr_data), 32'(m_wr_data));
        end
        check("pend", 32'(bus.pend), 32'(m_pend));
        check("stall_wb", 32'(bus.stall_wb), 32'(m_stall));
        check("err", 32'(bus.err), 32'(m_err));
        check("b_ready", 32'(bus.b_ready), 32'(bus.b_valid && !bus.a_valid));
        check("rd1_busy", 32'(bus.rd1_busy), 32'(busy_of(m_pend, bus.rd1_addr)));
        check("rd2_busy", 32'(bus.rd2_busy), 32'(busy_of(m_pend, bus.rd2_addr)));
        check("wd_busy", 32'(bus.wd_busy), 32'(busy_of(m_pend, bus.wd_addr)));
      end
      if (rst) begin
        m_wr_en = 0; m_wr_b = 0; m_err = 0; m_stall = 0;
        m_wr_addr = 0; m_wr_data = 0; m_pend = 0; m_streak = 0;
        chk_en = 1;
      end else begin
        clr = m_wr_en && m_wr_b;
        np  = m_pend;
        ne  = m_err;
        if (clr) begin
          if (!m_pend[m_wr_addr]) ne = 1;
          np[m_wr_addr] = 0;
        end
        if (bus.iss_valid) begin
          if (m_pend[bus.iss_reg] && !(clr && m_wr_addr == bus.iss_reg)) ne = 1;
          if (!(R0_ZERO && bus.iss_reg == 4'd0)) np[bus.iss_reg] = 1;
        end
        if (m_stall) begin
          if (bus.a_valid) ne = 1;
          m_streak = (bus.a_valid && bus.b_valid) ? int'(MAX_WAIT) - 1 : 0;
          m_stall  = 0;
        end else if (bus.a_valid && bus.b_valid) begin
          m_streak++;
          m_stall = (m_streak == int'(MAX_WAIT));
          if (m_stall) m_streak = 0;
        end else begin
          m_streak = 0;
        end
        if (bus.a_valid || bus.b_valid) begin
          wa        = bus.a_valid ? bus.a_reg : bus.b_reg;
          m_wr_addr = wa;
          m_wr_data = bus.a_valid ? bus.a_data : bus.b_data;
          m_wr_b    = !bus.a_valid;
          m_wr_en   = !(R0_ZERO && wa == 4'd0);
        end else begin
          m_wr_en = 0;
          m_wr_b  = 0;
        end
        m_pend = np;
        m_err  = ne;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.a_valid = 0; bus.a_reg = 0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_reg = 0; bus.b_data = 0;
    bus.iss_valid = 0; bus.iss_reg = 0;
    bus.rd1_addr = 0; bus.rd2_addr = 0; bus.wd_addr = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    step();
    step();
    rst = 0;
  endtask

  task automatic rand_cycles(input int n, input int a_pct);
    bit       hold_b;
    bit [3:0] r;
    hold_b = 0;
    for (int i = 0; i < n; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.a_valid = ($urandom_range(0, 99) < a_pct);
      if (bus.stall_wb && $urandom_range(0, 9) != 0) bus.a_valid = 0;
      bus.a_reg  = 4'($urandom_range(0, 15));
      bus.a_data = 16'($urandom);
      if (!hold_b) begin
        bus.b_valid = ($urandom_range(0, 99) < 40);
        r = 4'($urandom_range(0, 15));
        for (int t = 0; t < 6 && !m_pend[r]; t++) r = 4'($urandom_range(0, 15));
        bus.b_reg  = r;
        bus.b_data = 16'($urandom);
      end
      bus.iss_valid = ($urandom_range(0, 99) < 30);
      r = 4'($urandom_range(0, 15));
      for (int t = 0; t < 6 && m_pend[r]; t++) r = 4'($urandom_range(0, 15));
      bus.iss_reg  = r;
      bus.rd1_addr = 4'($urandom_range(0, 15));
      bus.rd2_addr = 4'($urandom_range(0, 15));
      bus.wd_addr  = 4'($urandom_range(0, 15));
      #1;
      hold_b = bus.b_valid && !bus.b_ready;
      step();
    end
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1;
    idle_inputs();
    do_reset();

    // Reset then idle
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check("rst_pend", 32'(bus.pend), 32'h0000);
    check("rst_b_ready", 32'(bus.b_ready), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_stall", 32'(bus.stall_wb), 32'd0);

    // A only
    bus.a_valid = 1; bus.a_reg = 3; bus.a_data = 16'hBEEF;
    step();
    bus.a_valid = 0;
    check("a_wr_en", 32'(bus.wr_en), 32'd1);
    check("a_wr_addr", 32'(bus.wr_addr), 32'd3);
    check("a_wr_data", 32'(bus.wr_data), 32'hBEEF);
    step();
    check("a_wr_en_drop", 32'(bus.wr_en), 32'd0);

    // Load round trip
    bus.iss_valid = 1; bus.iss_reg = 5;
    step();
    bus.iss_valid = 0; bus.rd1_addr = 5;
    #1;
    check("ld_pend_set", 32'(bus.pend), 32'h0020);
    check("ld_rd1_busy", 32'(bus.rd1_busy), 32'd1);
    bus.b_valid = 1; bus.b_reg = 5; bus.b_data = 16'h1234;
    #1;
    check("ld_b_ready", 32'(bus.b_ready), 32'd1);
    step();
    bus.b_valid = 0;
    check("ld_wr_en", 32'(bus.wr_en), 32'd1);
    check("ld_wr_addr", 32'(bus.wr_addr), 32'd5);
    check("ld_wr_data", 32'(bus.wr_data), 32'h1234);
    check("ld_pend_held", 32'(bus.pend), 32'h0020);
    step();
    check("ld_pend_clr", 32'(bus.pend), 32'h0000);

    // Collision and starvation
    bus.iss_valid = 1; bus.iss_reg = 6;
    step();
    bus.iss_valid = 0;
    bus.a_valid = 1; bus.a_reg = 2; bus.a_data = 16'h0A0A;
    bus.b_valid = 1; bus.b_reg = 6; bus.b_data = 16'h6666;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("col_b_ready", 32'(bus.b_ready), 32'd0);
      check("col_stall_lo", 32'(bus.stall_wb), 32'd0);
      step();
    end
    check("col_stall_hi", 32'(bus.stall_wb), 32'd1);
    bus.a_valid = 0;
    #1;
    check("force_b_ready", 32'(bus.b_ready), 32'd1);
    step();
    bus.b_valid = 0;
    check("force_wr_en", 32'(bus.wr_en), 32'd1);
    check("force_wr_addr", 32'(bus.wr_addr), 32'd6);
    check("force_wr_data", 32'(bus.wr_data), 32'h6666);
    check("force_stall_lo", 32'(bus.stall_wb), 32'd0);
    step();
    check("force_pend_clr", 32'(bus.pend), 32'h0000);
    check("force_err", 32'(bus.err), 32'd0);

    // Same-edge set and clear of reg 7
    bus.iss_valid = 1; bus.iss_reg = 7;
    step();
    bus.iss_valid = 0;
    bus.b_valid = 1; bus.b_reg = 7; bus.b_data = 16'h7777;
    step();
    bus.b_valid = 0;
    bus.iss_valid = 1; bus.iss_reg = 7;
    step();
    bus.iss_valid = 0;
    check("same_edge_pend", 32'(bus.pend), 32'h0080);
    check("same_edge_err", 32'(bus.err), 32'd0);
    bus.b_valid = 1; bus.b_reg = 7;
    step();
    bus.b_valid = 0;
    step();
    check("same_edge_clr", 32'(bus.pend), 32'h0000);

    // Writes to R0 are consumed but never reach the port
    bus.a_valid = 1; bus.a_reg = 0; bus.a_data = 16'h5555;
    step();
    bus.a_valid = 0;
    check("r0_wr_en", 32'(bus.wr_en), 32'd0);
    step();

    // Randomized traffic with varying writeback pressure
    do_reset();
    rand_cycles(300, 50);
    do_reset();
    rand_cycles(300, 85);
    do_reset();
    rand_cycles(300, 30);

    // Issue to an already-pending reg is a sticky error
    do_reset();
    bus.iss_valid = 1; bus.iss_reg = 9;
    step();
    step();
    bus.iss_valid = 0;
    check("dup_iss_err", 32'(bus.err), 32'd1);
    step();
    step();
    step();
    check("dup_iss_sticky", 32'(bus.err), 32'd1);
    check("dup_iss_pend", 32'(bus.pend), 32'h0200);

    // Reset while waiting
    bus.a_valid = 1; bus.a_reg = 1; bus.a_data = 16'h1111;
    bus.b_valid = 1; bus.b_reg = 9; bus.b_data = 16'h9999;
    step();
    step();
    rst = 1;
    step();
    rst = 0;
    idle_inputs();
    check("rstw_stall", 32'(bus.stall_wb), 32'd0);
    check("rstw_pend", 32'(bus.pend), 32'h0000);
    check("rstw_err", 32'(bus.err), 32'd0);
    check("rstw_wr_en", 32'(bus.wr_en), 32'd0);
    check("rstw_wr_addr", 32'(bus.wr_addr), 32'd0);
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_write_sched.md
Name: rf_write_sched

Overview:
- Write-port scheduler and load scoreboard for the 16x16-bit register file.
- Shares the single register-file write port between two sources:
  - pipeline writeback (source A, cannot be back-pressured);
  - long-latency load returns from the memory/cache side (source B, valid/ready).
- Tracks registers with an outstanding load so issue logic can stall RAW/WAW hazards.
- Prevents B starvation by requesting a one-cycle pipeline writeback bubble.

Parameters:
- MAX_WAIT, 4, consecutive cycles B may be refused before a forced B slot is requested (1..15)
- R0_ZERO, 1, when 1 writes to register 0 are suppressed (wr_en stays 0) and R0 is never marked pending

Ports:
- clk  input  1  clock, all state on posedge
- rst  input  1  synchronous reset, active-high
- a_valid  input  1  pipeline writeback valid this cycle
- a_reg  input  4  writeback destination
- a_data  input  16  writeback data
- b_valid  input  1  load return valid
- b_ready  output  1  load return accepted this cycle (combinational)
- b_reg  input  4  load destination
- b_data  input  16  load data
- iss_valid  input  1  load issued this cycle (marks iss_reg pending)
- iss_reg  input  4  destination of issued load
- rd1_addr, rd2_addr, wd_addr  input  4 each  hazard lookup addresses (source 1, source 2, destination)
- rd1_busy, rd2_busy, wd_busy  output  1 each  lookup address has a pending load (combinational from pend)
- stall_wb  output  1  registered request to pipeline: present no writeback next cycle
- wr_en  output  1  register-file write enable (registered)
- wr_addr  output  4  register-file write address (registered)
- wr_data  output  16  register-file write data (registered)
- pend  output  16  pending-load bitmap
- err  output  1  sticky protocol-violation flag

Behaviour:
- Reset: wr_en=0, wr_addr=0, wr_data=0, pend=0, stall_wb=0, err=0, wait count=0, state=IDLE.
- Arbitration (combinational, each cycle):
  - A always wins when a_valid=1.
  - b_ready = b_valid & ~a_valid.
  - Winner's addr/data are captured into wr_* at the next edge: 1-cycle latency, wr_en=1 for exactly one cycle per grant.
- R0 suppression: with R0_ZERO=1, a winner targeting reg 0 is still consumed (b_ready follows the normal rule), but wr_en stays 0.
- Scoreboard, applied at the edge where the write occurs:
  - pend[wr_addr] clears at the edge ending a cycle in which wr_en=1 and the write came from B.
  - Write source is tracked in an internal registered bit.
  - pend[iss_reg] sets on iss_valid.
  - Set and clear of the same bit on the same edge: set wins.
  - busy outputs = pend[addr]; reg 0 never busy when R0_ZERO=1.
- Starvation state machine:
  - IDLE: b_valid & a_valid -> WAIT, count=1.
  - WAIT: B refused -> count+1. B accepted or b_valid=0 -> IDLE, count=0. Refused with count==MAX_WAIT-1 -> FORCE, stall_wb<=1.
  - FORCE, stall_wb=1, lasts exactly one cycle: the pipeline must hold a_valid=0 in this cycle, so B is granted.
    - b_valid=0 in FORCE: no write; go to IDLE.
    - a_valid=1 in FORCE: A still wins, err<=1, go to WAIT with count=MAX_WAIT-1 (retry on next refusal).
    - Otherwise -> IDLE.
- Protocol errors (err set, state otherwise unaffected):
  - iss_valid to a reg already pending and not being cleared that edge;
  - B write to a reg whose pend bit is 0.
- err clears only on rst.
- rst asserted mid-operation: all state and outputs return to reset values at that edge; any in-flight B return is dropped.

Test Plan:
- Reset then idle: wr_en=0, pend=16'h0000, b_ready=0, err=0.
- A only: a_valid=1, a_reg=3, a_data=16'hBEEF -> next cycle wr_en=1, wr_addr=3, wr_data=16'hBEEF; following cycle wr_en=0.
- Load round trip:
  - iss_valid, iss_reg=5 -> pend=16'h0020, rd1_busy=1 for rd1_addr=5.
  - b_valid, b_reg=5, b_data=16'h1234 -> b_ready=1; next cycle wr_* = 5/16'h1234; after that edge pend=0.
- Collision and starvation, MAX_WAIT=4: a_valid and b_valid held for 4 cycles -> b_ready=0 throughout, stall_wb=1 in cycle 5; bench drops a_valid -> b_ready=1, B written next cycle, state IDLE.
- Same-edge set/clear: B write of reg 7 committing in the same cycle as iss_valid, iss_reg=7 -> pend[7]=1 afterwards, err=0.
- Edge cases:
  - R0_ZERO=1, a_reg=0 -> no wr_en.
  - iss to already-pending reg 9 -> err=1, stays 1 until rst.
  - rst during WAIT -> stall_wb=0, pend=0.
